d_mem_arb: RTL and testbench

- Arbitrates one d_mem_wrap port between two requesters:
  - the gpc_4t core pipeline, which is the priority requester;
  - the ring/fabric slave path, which carries external SOC loads and stores into the tile's data and MMIO space.
- A starvation counter guarantees the ring progress under continuous core traffic.
- Ring reads return through a 1-entry response buffer with valid/ready flow control.
- Sits between core memory stage, ring interface and d_mem_wrap.

---
 rtl/d_mem_arb_pkg.sv | 29 ++
 rtl/d_mem_arb_rsp_buf.sv | 44 ++++
 rtl/d_mem_arb.sv | 150 +++++++++++++++
 tb/tb_d_mem_arb.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_mem_arb_pkg.sv
// Shared types and defaults for the d_mem port arbiter (core pipeline vs. ring slave).
package d_mem_arb_pkg;

    localparam int D_MEM_ARB_STARVE_MAX = 4;
    localparam int RING_ID_W            = 8;

    typedef struct packed {
        logic                 wr;
        logic [31:0]          addr;
        logic [3:0]           be;
        logic [31:0]          data;
        logic [RING_ID_W-1:0] id;
    } t_ring_req;

    typedef struct packed {
        logic [31:0]          data;
        logic [RING_ID_W-1:0] id;
    } t_ring_rsp;

    // One d_mem_wrap access as presented by whichever requester won the cycle.
    typedef struct packed {
        logic        rden;
        logic        wren;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } t_mem_cmd;

endpackage

// File: rtl/d_mem_arb_rsp_buf.sv
// One-entry holding register for ring read responses, loaded from mem_q the cycle
// after a ring read is issued and drained by a valid/ready handshake.
module d_mem_arb_rsp_buf
    import d_mem_arb_pkg::*;
#(
    parameter int ID_W = RING_ID_W
) (
    input  logic            clock,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic [31:0]     i_load_data,
    input  logic [ID_W-1:0] i_load_id,
    input  logic            i_ready,
    output logic            o_valid,
    output logic [31:0]     o_data,
    output logic [ID_W-1:0] o_id
);

    logic            r_full;
    logic [31:0]     r_data;
    logic [ID_W-1:0] r_id;

    // Handshake: a response transfers on any cycle with o_valid && i_ready; data and
    // id stay stable while o_valid is high and i_ready is low. The arbiter never
    // issues a ring read while this buffer is full, so a load never meets a full entry.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_id   <= '0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_load_data;
            r_id   <= i_load_id;
        end else if (r_full && i_ready) begin
            r_full <= 1'b0;
        end
    end

    assign o_valid = r_full;
    assign o_data  = r_data;
    assign o_id    = r_id;

endmodule

// File: rtl/d_mem_arb.sv
// Arbitrates the single d_mem_wrap port between the core pipeline (priority) and the
// ring slave path. Define D_MEM_ARB_PERF_EN to add saturating stall/starve counters.
module d_mem_arb
    import d_mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = D_MEM_ARB_STARVE_MAX,
    parameter int ID_W       = RING_ID_W
) (
    input  logic            clock,
    input  logic            rst_n,
    input  logic            core_rden,
    input  logic            core_wren,
    input  logic [31:0]     core_addr,
    input  logic [3:0]      core_byteena,
    input  logic [31:0]     core_wdata,
    output logic            core_stall,
    output logic [31:0]     core_rdata,
    input  logic            ring_req_valid,
    output logic            ring_req_ready,
    input  logic            ring_req_wr,
    input  logic [31:0]     ring_req_addr,
    input  logic [3:0]      ring_req_be,
    input  logic [31:0]     ring_req_data,
    input  logic [ID_W-1:0] ring_req_id,
    output logic            ring_rsp_valid,
    input  logic            ring_rsp_ready,
    output logic [31:0]     ring_rsp_data,
    output logic [ID_W-1:0] ring_rsp_id,
    output logic [31:0]     mem_address,
    output logic [3:0]      mem_byteena,
    output logic [31:0]     mem_data,
    output logic            mem_rden,
    output logic            mem_wrren,
`ifdef D_MEM_ARB_PERF_EN
    input  logic            perf_clr,
    output logic [15:0]     perf_stall_cnt,
    output logic [15:0]     perf_starve_cnt,
`endif
    input  logic [31:0]     mem_q
);

    logic            r_rd_inflight;
    logic [ID_W-1:0] r_rd_id;
    logic [3:0]      r_starve_cnt;

    logic            w_core_act;
    logic            w_rsp_full;
    logic            w_ring_ok;
    logic            w_ring_win;
    logic            w_starved;
    logic            w_ring_rd_win;
    t_mem_cmd        w_cmd;

    assign w_core_act    = core_rden | core_wren;
    assign w_starved     = (r_starve_cnt == 4'(STARVE_MAX));
    // Writes are posted, so only reads depend on the response path being empty.
    assign w_ring_ok     = ring_req_valid && (ring_req_wr || (!r_rd_inflight && !w_rsp_full));
    assign w_ring_win    = w_ring_ok && (!w_core_act || w_starved);
    assign w_ring_rd_win = w_ring_win && !ring_req_wr;

    assign ring_req_ready = w_ring_win;
    assign core_stall     = w_core_act && w_ring_win;
    assign core_rdata     = mem_q;

    always_comb begin
        w_cmd = '0;
        if (w_ring_win) begin
            w_cmd.rden = !ring_req_wr;
            w_cmd.wren = ring_req_wr;
            w_cmd.addr = ring_req_addr;
            w_cmd.be   = ring_req_be;
            w_cmd.data = ring_req_data;
        end else if (w_core_act) begin
            w_cmd.rden = core_rden;
            w_cmd.wren = core_wren;
            w_cmd.addr = core_addr;
            w_cmd.be   = core_byteena;
            w_cmd.data = core_wdata;
        end
    end

    assign mem_rden    = w_cmd.rden;
    assign mem_wrren   = w_cmd.wren;
    assign mem_address = w_cmd.addr;
    assign mem_byteena = w_cmd.be;
    assign mem_data    = w_cmd.data;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_inflight <= 1'b0;
            r_rd_id       <= '0;
            r_starve_cnt  <= '0;
        end else begin
            r_rd_inflight <= w_ring_rd_win;
            if (w_ring_rd_win) begin
                r_rd_id <= ring_req_id;
            end
            if (!w_ring_ok || w_ring_win) begin
                r_starve_cnt <= '0;
            end else if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

    d_mem_arb_rsp_buf #(
        .ID_W (ID_W)
    ) u_rsp_buf (
        .clock       (clock),
        .rst_n       (rst_n),
        .i_load      (r_rd_inflight),
        .i_load_data (mem_q),
        .i_load_id   (r_rd_id),
        .i_ready     (ring_rsp_ready),
        .o_valid     (w_rsp_full),
        .o_data      (ring_rsp_data),
        .o_id        (ring_rsp_id)
    );

    assign ring_rsp_valid = w_rsp_full;

`ifdef D_MEM_ARB_PERF_EN
    logic [15:0] r_perf_stall_cnt;
    logic [15:0] r_perf_starve_cnt;
    logic        w_forced;

    assign w_forced = w_starved && w_core_act && w_ring_win;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall_cnt  <= '0;
            r_perf_starve_cnt <= '0;
        end else if (perf_clr) begin
            r_perf_stall_cnt  <= '0;
            r_perf_starve_cnt <= '0;
        end else begin
            if (core_stall && (r_perf_stall_cnt != 16'hFFFF)) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 16'd1;
            end
            if (w_forced && (r_perf_starve_cnt != 16'hFFFF)) begin
                r_perf_starve_cnt <= r_perf_starve_cnt + 16'd1;
            end
        end
    end

    assign perf_stall_cnt  = r_perf_stall_cnt;
    assign perf_starve_cnt = r_perf_starve_cnt;
`endif

endmodule

// File: tb/tb_d_mem_arb.sv
// Bench for d_mem_arb: directed scenarios then random traffic against a cycle-level
// reference model and a behavioural d_mem_wrap.
module tb_d_mem_arb;
    import d_mem_arb_pkg::*;

    localparam int STARVE_MAX = 4;
    localparam int ID_W       = 8;

    logic            clock;
    logic            rst_n;
    logic            core_rden, core_wren;
    logic [31:0]     core_addr, core_wdata;
    logic [3:0]      core_byteena;
    logic            core_stall;
    logic [31:0]     core_rdata;
    logic            ring_req_valid, ring_req_ready, ring_req_wr;
    logic [31:0]     ring_req_addr, ring_req_data;
    logic [3:0]      ring_req_be;
    logic [ID_W-1:0] ring_req_id;
    logic            ring_rsp_valid, ring_rsp_ready;
    logic [31:0]     ring_rsp_data;
    logic [ID_W-1:0] ring_rsp_id;
    logic [31:0]     mem_address, mem_data, mem_q;
    logic [3:0]      mem_byteena;
    logic            mem_rden, mem_wrren;
    logic            perf_clr;
`ifdef D_MEM_ARB_PERF_EN
    logic [15:0]     perf_stall_cnt, perf_starve_cnt;
`endif

    d_mem_arb #(.STARVE_MAX(STARVE_MAX), .ID_W(ID_W)) dut (
        .clock          (clock),
        .rst_n          (rst_n),
        .core_rden      (core_rden),
        .core_wren      (core_wren),
        .core_addr      (core_addr),
        .core_byteena   (core_byteena),
        .core_wdata     (core_wdata),
        .core_stall     (core_stall),
        .core_rdata     (core_rdata),
        .ring_req_valid (ring_req_valid),
        .ring_req_ready (ring_req_ready),
        .ring_req_wr    (ring_req_wr),
        .ring_req_addr  (ring_req_addr),
        .ring_req_be    (ring_req_be),
        .ring_req_data  (ring_req_data),
        .ring_req_id    (ring_req_id),
        .ring_rsp_valid (ring_rsp_valid),
        .ring_rsp_ready (ring_rsp_ready),
        .ring_rsp_data  (ring_rsp_data),
        .ring_rsp_id    (ring_rsp_id),
        .mem_address    (mem_address),
        .mem_byteena    (mem_byteena),
        .mem_data       (mem_data),
        .mem_rden       (mem_rden),
        .mem_wrren      (mem_wrren),
`ifdef D_MEM_ARB_PERF_EN
        .perf_clr       (perf_clr),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_starve_cnt(perf_starve_cnt),
`endif
        .mem_q          (mem_q)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- d_mem_wrap stand-in ----------------
    logic [31:0] dmem    [0:1023];
    logic [31:0] ref_mem [0:1023];

    function automatic int idx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] w;
        w = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        return w;
    endfunction

    always @(posedge clock) begin
        if (mem_rden) mem_q <= dmem[idx(mem_address)];
        if (mem_wrren) dmem[idx(mem_address)] <= merge(dmem[idx(mem_address)], mem_data, mem_byteena);
    end

    // ---------------- scoreboard / reference model ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [39:0] exp_q[$];      // {id, data} of ring reads owed a response
    int          exp_vis_q[$];  // cycle from which that response must be visible
    int          m_lose;
    logic        m_core_pend;
    logic [31:0] m_core_exp;
    int          m_stall_cnt, m_forced_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        core_rden = 0; core_wren = 0; core_addr = 0; core_byteena = 0; core_wdata = 0;
        ring_req_valid = 0; ring_req_wr = 0; ring_req_addr = 0; ring_req_be = 0;
        ring_req_data = 0; ring_req_id = 0; perf_clr = 0;
    endtask

    // One clock cycle: entered at the falling edge with inputs already applied.
    task automatic cycle();
        logic core_act, ring_ok, win, forced, exp_valid, e_rd, e_wr;
        logic [31:0] e_addr, e_data;
        logic [3:0]  e_be;
        #2;
        core_act = core_rden | core_wren;
        ring_ok  = ring_req_valid && (ring_req_wr || exp_q.size() == 0);
        win      = ring_ok && (!core_act || m_lose == STARVE_MAX);
        forced   = (m_lose == STARVE_MAX) && core_act && win;
        e_rd = 0; e_wr = 0; e_addr = 0; e_be = 0; e_data = 0;
        if (win) begin
            e_rd = !ring_req_wr; e_wr = ring_req_wr; e_addr = ring_req_addr;
            e_be = ring_req_be;  e_data = ring_req_data;
        end else if (core_act) begin
            e_rd = core_rden; e_wr = core_wren; e_addr = core_addr;
            e_be = core_byteena; e_data = core_wdata;
        end
        chk("req_ready", 32'(ring_req_ready), 32'(win));
        chk("core_stall", 32'(core_stall), 32'(core_act && win));
        chk("mem_rden", 32'(mem_rden), 32'(e_rd));
        chk("mem_wrren", 32'(mem_wrren), 32'(e_wr));
        chk("mem_address", mem_address, e_addr);
        chk("mem_byteena", 32'(mem_byteena), 32'(e_be));
        chk("mem_data", mem_data, e_data);
        exp_valid = (exp_q.size() != 0) && (cyc >= exp_vis_q[0]);
        chk("rsp_valid", 32'(ring_rsp_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("rsp_data", ring_rsp_data, exp_q[0][31:0]);
            chk("rsp_id", 32'(ring_rsp_id), 32'(exp_q[0][39:32]));
        end
        if (m_core_pend) chk("core_rdata", core_rdata, m_core_exp);
        @(posedge clock);
        m_core_pend = 0;
        if (exp_valid && ring_rsp_ready) begin
            void'(exp_q.pop_front());
            void'(exp_vis_q.pop_front());
        end
        if (win && !ring_req_wr) begin
            exp_q.push_back({ring_req_id, ref_mem[idx(ring_req_addr)]});
            exp_vis_q.push_back(cyc + 2);
        end
        if (!win && core_rden) begin
            m_core_pend = 1;
            m_core_exp  = ref_mem[idx(core_addr)];
        end
        if (e_wr) ref_mem[idx(e_addr)] = merge(ref_mem[idx(e_addr)], e_data, e_be);
        if (ring_ok && !win) m_lose = (m_lose < STARVE_MAX) ? m_lose + 1 : STARVE_MAX;
        else m_lose = 0;
        if (perf_clr) begin
            m_stall_cnt = 0; m_forced_cnt = 0;
        end else begin
            if (core_act && win) m_stall_cnt++;
            if (forced) m_forced_cnt++;
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        #1;
        chk("rst_rsp_valid", 32'(ring_rsp_valid), 32'd0);
        chk("rst_rsp_data", ring_rsp_data, 32'd0);
        chk("rst_rsp_id", 32'(ring_rsp_id), 32'd0);
        chk("rst_req_ready", 32'(ring_req_ready), 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        exp_vis_q.delete();
        m_lose = 0; m_core_pend = 0; m_stall_cnt = 0; m_forced_cnt = 0;
    endtask

    // Core reads every cycle against a ring request: ring must lose STARVE_MAX cycles.
    task automatic starve_run(input logic wr, input logic [31:0] raddr);
        core_rden = 1; core_addr = 32'h0040_0400; core_byteena = 4'hF;
        ring_req_valid = 1; ring_req_wr = wr; ring_req_addr = raddr;
        ring_req_be = 4'hF; ring_req_data = 32'hA5A5_0000; ring_req_id = 8'h77;
        for (int i = 0; i <= STARVE_MAX; i++) begin
            #1;
            chk("starve_ready", 32'(ring_req_ready), 32'(i == STARVE_MAX));
            chk("starve_stall", 32'(core_stall), 32'(i == STARVE_MAX));
            cycle();
        end
        set_idle();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        for (int i = 0; i < 1024; i++) begin
            dmem[i]    = 32'(i) * 32'h9E37_79B9;
            ref_mem[i] = 32'(i) * 32'h9E37_79B9;
        end
        dmem[256] = 32'hDEAD_BEEF;
        ref_mem[256] = 32'hDEAD_BEEF;
        mem_q = 0;
        ring_rsp_ready = 1;
        set_idle();
        rst_n = 1'b0;
        @(negedge clock);
        do_reset();
        cycle();

        // core read of preloaded word
        core_rden = 1; core_addr = 32'h0040_0400; core_byteena = 4'hF;
        #1;
        chk("core_rd_strobe", 32'(mem_rden), 32'd1);
        cycle();
        set_idle();
        #1;
        chk("core_rd_data", core_rdata, 32'hDEAD_BEEF);
        chk("core_rd_nostall", 32'(core_stall), 32'd0);
        cycle();

        // ring write then ring read of the same word
        ring_req_valid = 1; ring_req_wr = 1; ring_req_addr = 32'h0040_0800;
        ring_req_be = 4'hF; ring_req_data = 32'h1234_5678; ring_req_id = 8'h11;
        #1;
        chk("ring_wr_ready", 32'(ring_req_ready), 32'd1);
        chk("ring_wr_wren", 32'(mem_wrren), 32'd1);
        cycle();
        ring_req_wr = 0; ring_req_id = 8'h5A; ring_req_data = 0;
        cycle();
        set_idle();
        cycle();
        #1;
        chk("ring_rd_valid_t2", 32'(ring_rsp_valid), 32'd1);
        chk("ring_rd_data_t2", ring_rsp_data, 32'h1234_5678);
        chk("ring_rd_id_t2", 32'(ring_rsp_id), 32'h5A);
        cycle();

        // starvation with a read, then a write to show the counter restarted
        starve_run(1'b0, 32'h0040_0800);
        repeat (4) cycle();
        starve_run(1'b1, 32'h0040_0C00);
        cycle();

        // response held under back-pressure; writes still pass, reads do not
        ring_rsp_ready = 0;
        ring_req_valid = 1; ring_req_wr = 0; ring_req_addr = 32'h0040_0800;
        ring_req_be = 4'hF; ring_req_id = 8'h33;
        cycle();
        for (int i = 0; i < 10; i++) begin
            ring_req_wr = i[0]; ring_req_addr = i[0] ? 32'h0040_0900 : 32'h0040_0800;
            ring_req_data = $urandom;
            #1;
            chk("bp_ready", 32'(ring_req_ready), 32'(i[0]));
            if (i > 0) begin
                chk("bp_hold_data", ring_rsp_data, 32'h1234_5678);
                chk("bp_hold_id", 32'(ring_rsp_id), 32'h33);
            end
            cycle();
        end
        ring_req_wr = 0; ring_req_addr = 32'h0040_0800; ring_req_id = 8'h34;
        ring_rsp_ready = 1;
        #1;
        chk("bp_handshake_block", 32'(ring_req_ready), 32'd0);
        cycle();
        #1;
        chk("bp_after_accept", 32'(ring_req_ready), 32'd1);
        cycle();
        set_idle();
        repeat (4) cycle();

        // reset one cycle after a ring read grant drops the read
        ring_req_valid = 1; ring_req_wr = 0; ring_req_addr = 32'h0040_0400; ring_req_id = 8'h99;
        cycle();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rst_drop_valid", 32'(ring_rsp_valid), 32'd0);
            cycle();
        end
        starve_run(1'b1, 32'h0040_0C04);
        cycle();

`ifdef D_MEM_ARB_PERF_EN
        perf_clr = 1;
        cycle();
        perf_clr = 0;
        core_rden = 1; core_addr = 32'h0040_0400; core_byteena = 4'hF;
        ring_req_valid = 1; ring_req_wr = 1; ring_req_addr = 32'h0040_0C08;
        ring_req_be = 4'hF; ring_req_data = 32'h0BAD_F00D;
        repeat (20) cycle();
        set_idle();
        #1;
        chk("perf_starve_20", 32'(perf_starve_cnt), 32'd4);
        chk("perf_stall_20", 32'(perf_stall_cnt), 32'd4);
        perf_clr = 1;
        cycle();
        perf_clr = 0;
        #1;
        chk("perf_starve_clr", 32'(perf_starve_cnt), 32'd0);
        chk("perf_stall_clr", 32'(perf_stall_cnt), 32'd0);
`endif

        // random traffic
        for (int n = 0; n < 600; n++) begin
            int sel;
            sel = int'($urandom_range(0, 2));
            core_rden = (sel == 1); core_wren = (sel == 2);
            core_addr = 32'h0040_0000 | (32'($urandom_range(0, 15)) << 2);
            core_byteena = 4'($urandom_range(0, 15));
            core_wdata = $urandom;
            ring_req_valid = ($urandom_range(0, 2) != 0);
            ring_req_wr = 1'($urandom_range(0, 1));
            ring_req_addr = 32'h0040_0000 | (32'($urandom_range(0, 15)) << 2);
            ring_req_be = 4'($urandom_range(0, 15));
            ring_req_data = $urandom;
            ring_req_id = 8'($urandom_range(0, 255));
            ring_rsp_ready = ($urandom_range(0, 3) != 0);
            perf_clr = ($urandom_range(0, 63) == 0);
            cycle();
        end
        set_idle();
        ring_rsp_ready = 1;
        repeat (4) cycle();
`ifdef D_MEM_ARB_PERF_EN
        #1;
        chk("perf_stall_rand", 32'(perf_stall_cnt), 32'(m_stall_cnt));
        chk("perf_starve_rand", 32'(perf_starve_cnt), 32'(m_forced_cnt));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
